min_os_scheduler: RTL and testbench
===================================

Name: min_os_scheduler

Overview:
- Parametrised successor to the single-interface MinOS FSM.
- Arbitrates N virtual interfaces round-robin onto one uart_tx_typed_chunker. Latches each winner's chunk, drives the chunker handshake and acknowledges the interface.
- Independently routes received typed chunks from uart_rx_typed_chunker to the interface whose chunk type matches.

Parameters:
- NUM_IFACES, 4, number of virtual interfaces (1..16)
- MAX_CHUNK_BYTES, 5, payload buffer size in bytes (TX and RX)
- SIZE_WIDTH, 32, width of all byte-size fields
- IFACE_TYPES, {8'd4,8'd3,8'd2,8'd1}, packed NUM_IFACES*8 chunk-type IDs; slice i belongs to iface i, used for RX routing
- TIMEOUT_CYCLES, 1000000, chunker-done watchdog limit (optional feature only)

Ports:
- CLK  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- iface_req  in  NUM_IFACES  per-iface "should_update" level
- iface_type  in  NUM_IFACES*8  per-iface TX chunk type
- iface_bytes  in  NUM_IFACES*MAX_CHUNK_BYTES*8  per-iface payload; byte 0 in LSBs
- iface_size  in  NUM_IFACES*SIZE_WIDTH  per-iface payload length in bytes
- iface_ack  out  NUM_IFACES  one-cycle "update consumed" pulse (one-hot)
- tx_is_chunk_ready  out  1  chunker start strobe
- tx_chunk_type  out  8  latched chunk type
- tx_chunk_bytes  out  MAX_CHUNK_BYTES*8  latched payload
- tx_chunk_byte_size  out  SIZE_WIDTH  latched, clamped length
- tx_is_chunker_done  in  1  chunker completion pulse
- rx_is_chunk_ready  in  1  received-chunk pulse
- rx_chunk_type  in  8  received type
- rx_chunk_bytes  in  MAX_CHUNK_BYTES*8  received payload
- rx_chunk_byte_size  in  SIZE_WIDTH  received length
- iface_rx_valid  out  NUM_IFACES  one-hot pulse, routed chunk
- iface_rx_bytes  out  MAX_CHUNK_BYTES*8  shared registered payload
- iface_rx_size  out  SIZE_WIDTH  shared registered length
- rx_unknown  out  1  pulse, type matched no iface
- busy  out  1  high in every TX state except IDLE

Behaviour:
- Reset (async assert, sync release): all outputs 0, TX FSM to IDLE, round-robin pointer = NUM_IFACES-1 so iface 0 has first priority. Reset mid-transfer abandons the transfer; no ack is issued.
- TX FSM states:
  - IDLE: if any iface_req, grant the first requester searching from pointer+1 with wrap; latch its type, bytes and size; go to LOAD. Requests are sampled only in IDLE.
  - LOAD: tx_is_chunk_ready=1 and iface_ack[grant]=1 for this one cycle; pointer<=grant; go to STROBE.
  - STROBE: clear the strobe and ack; go to WAIT.
  - WAIT: on tx_is_chunker_done go to FINISH. A done pulse seen in any other state is ignored.
  - FINISH: one cycle, then IDLE.
- Latency: req high in IDLE at cycle 0 gives strobe and ack at cycle 1. Minimum gap between consecutive strobes is 4 cycles plus chunker time.
- Size rules:
  - iface_size > MAX_CHUNK_BYTES is clamped to MAX_CHUNK_BYTES.
  - iface_size == 0: no strobe; ack still pulses in LOAD; FSM goes LOAD->FINISH->IDLE and skips WAIT.
- Fairness: an iface requesting continuously is granted at most once per NUM_IFACES grants while others request. A lone requester is re-granted back to back.
- tx_chunk_* outputs hold their values from LOAD until the next LOAD.
- RX path: independent of the TX FSM, one-cycle registered latency.
  - On rx_is_chunk_ready, compare rx_chunk_type with IFACE_TYPES; the lowest matching index wins.
  - Next cycle: iface_rx_valid[idx]=1 with iface_rx_bytes/size loaded.
  - No match: rx_unknown=1 and bytes/size unchanged.
  - Size is clamped as for TX.
  - Back-to-back RX pulses each produce a pulse.

Optional Feature:
- Macro: MIN_OS_TX_TIMEOUT_EN.
- Defined: a counter runs in WAIT. If it reaches TIMEOUT_CYCLES without tx_is_chunker_done, the FSM goes to FINISH, an extra output tx_timeout (1 bit) pulses one cycle, and the pointer still advances. The counter clears on leaving WAIT.
- Undefined: no counter and no tx_timeout port; WAIT waits indefinitely.

Test Plan:
- Single req on iface 2 (type 8'h03, bytes 8'hA5, size 1); done pulsed 20 cycles after the strobe -> one strobe with type 03, bytes[7:0]=A5, size 1; iface_ack=4'b0100 in the same cycle; busy falls 2 cycles after done.
- iface_req=4'b1111 held high, done returned after 5 cycles each time -> grant order 0,1,2,3,0,1; exactly one ack per grant.
- iface 1 size=9 with MAX=5 -> tx_chunk_byte_size=5. iface 3 size=0 -> ack pulses, no strobe, back in IDLE 2 cycles later.
- RX type 8'h02 with payload 8'h5A -> iface_rx_valid=4'b0010 one cycle later, iface_rx_bytes[7:0]=5A. Type 8'h7F -> rx_unknown pulse, valid stays 0.
- reset_n low during WAIT -> all outputs 0 immediately; after release iface 0 wins over iface 3 when both request.
- MIN_OS_TX_TIMEOUT_EN with TIMEOUT_CYCLES=50, done never returned -> tx_timeout pulses 50 cycles into WAIT, FSM reaches IDLE, the next requester is served.

Source files
------------

// File: rtl/min_os_scheduler_if.sv
// Bus bundle between min_os_scheduler (master) and the iface/chunker side (slave).
// MIN_OS_TX_TIMEOUT_EN adds the tx_timeout pulse.
interface min_os_scheduler_if #(
  parameter int unsigned NUM_IFACES      = 4,
  parameter int unsigned MAX_CHUNK_BYTES = 5,
  parameter int unsigned SIZE_WIDTH      = 32
);
  logic [NUM_IFACES-1:0]                   iface_req;
  logic [NUM_IFACES*8-1:0]                 iface_type;
  logic [NUM_IFACES*MAX_CHUNK_BYTES*8-1:0] iface_bytes;
  logic [NUM_IFACES*SIZE_WIDTH-1:0]        iface_size;
  logic [NUM_IFACES-1:0]                   iface_ack;
  logic                                    tx_is_chunk_ready;
  logic [7:0]                              tx_chunk_type;
  logic [MAX_CHUNK_BYTES*8-1:0]            tx_chunk_bytes;
  logic [SIZE_WIDTH-1:0]                   tx_chunk_byte_size;
  logic                                    tx_is_chunker_done;
  logic                                    rx_is_chunk_ready;
  logic [7:0]                              rx_chunk_type;
  logic [MAX_CHUNK_BYTES*8-1:0]            rx_chunk_bytes;
  logic [SIZE_WIDTH-1:0]                   rx_chunk_byte_size;
  logic [NUM_IFACES-1:0]                   iface_rx_valid;
  logic [MAX_CHUNK_BYTES*8-1:0]            iface_rx_bytes;
  logic [SIZE_WIDTH-1:0]                   iface_rx_size;
  logic                                    rx_unknown;
  logic                                    busy;
`ifdef MIN_OS_TX_TIMEOUT_EN
  logic                                    tx_timeout;
`endif

  modport master (
    input  iface_req, iface_type, iface_bytes, iface_size, tx_is_chunker_done,
           rx_is_chunk_ready, rx_chunk_type, rx_chunk_bytes, rx_chunk_byte_size,
    output iface_ack, tx_is_chunk_ready, tx_chunk_type, tx_chunk_bytes, tx_chunk_byte_size,
           iface_rx_valid, iface_rx_bytes, iface_rx_size, rx_unknown, busy
`ifdef MIN_OS_TX_TIMEOUT_EN
    , output tx_timeout
`endif
  );

  modport slave (
    output iface_req, iface_type, iface_bytes, iface_size, tx_is_chunker_done,
           rx_is_chunk_ready, rx_chunk_type, rx_chunk_bytes, rx_chunk_byte_size,
    input  iface_ack, tx_is_chunk_ready, tx_chunk_type, tx_chunk_bytes, tx_chunk_byte_size,
           iface_rx_valid, iface_rx_bytes, iface_rx_size, rx_unknown, busy
`ifdef MIN_OS_TX_TIMEOUT_EN
    , input tx_timeout
`endif
  );
endinterface

// File: rtl/min_os_scheduler.sv
// Round-robin TX arbiter of N virtual interfaces onto one typed chunker, plus RX type router.
// Optional chunker-done watchdog: define MIN_OS_TX_TIMEOUT_EN.
module min_os_scheduler #(
  parameter int unsigned             NUM_IFACES      = 4,
  parameter int unsigned             MAX_CHUNK_BYTES = 5,
  parameter int unsigned             SIZE_WIDTH      = 32,
  parameter logic [NUM_IFACES*8-1:0] IFACE_TYPES     = {8'd4, 8'd3, 8'd2, 8'd1}
`ifdef MIN_OS_TX_TIMEOUT_EN
  , parameter int unsigned           TIMEOUT_CYCLES  = 1000000
`endif
) (
  input logic                CLK,
  input logic                reset_n,
  min_os_scheduler_if.master bus
);
  localparam int unsigned PTR_W = (NUM_IFACES > 1) ? $clog2(NUM_IFACES) : 1;
  localparam int unsigned BW    = MAX_CHUNK_BYTES * 8;
  localparam logic [SIZE_WIDTH-1:0] MAX_SIZE = SIZE_WIDTH'(MAX_CHUNK_BYTES);

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_STROBE, ST_WAIT, ST_FINISH} state_t;

  state_t                 state, state_nx;
  logic [PTR_W-1:0]       ptr, grant, pick;
  logic                   found;
  int unsigned            cand;
  logic [7:0]             tx_type;
  logic [BW-1:0]          tx_bytes;
  logic [SIZE_WIDTH-1:0]  tx_size;
  logic [NUM_IFACES-1:0]  ack;
  logic                   strobe;

  function automatic logic [SIZE_WIDTH-1:0] clamp(input logic [SIZE_WIDTH-1:0] s);
    return (s > MAX_SIZE) ? MAX_SIZE : s;
  endfunction

  // First requester after the last winner, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int unsigned k = 1; k <= NUM_IFACES; k++) begin
      cand = (32'(ptr) + k) % NUM_IFACES;
      if (!found && bus.iface_req[cand]) begin
        found = 1'b1;
        pick  = PTR_W'(cand);
      end
    end
  end

`ifdef MIN_OS_TX_TIMEOUT_EN
  logic [31:0] wait_cnt;
  logic        timeout;
`endif

  always_comb begin
    state_nx = state;
    ack      = '0;
    strobe   = 1'b0;
`ifdef MIN_OS_TX_TIMEOUT_EN
    timeout  = 1'b0;
`endif
    case (state)
      ST_IDLE:   if (found) state_nx = ST_LOAD;
      ST_LOAD: begin
        ack[grant] = 1'b1;
        strobe     = (tx_size != '0);
        state_nx   = (tx_size != '0) ? ST_STROBE : ST_FINISH;
      end
      ST_STROBE: state_nx = ST_WAIT;
      ST_WAIT: begin
        if (bus.tx_is_chunker_done) begin
          state_nx = ST_FINISH;
        end
`ifdef MIN_OS_TX_TIMEOUT_EN
        else if (wait_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          timeout  = 1'b1;
          state_nx = ST_FINISH;
        end
`endif
      end
      ST_FINISH: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      ptr      <= PTR_W'(NUM_IFACES - 1);
      grant    <= '0;
      tx_type  <= '0;
      tx_bytes <= '0;
      tx_size  <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && found) begin
        grant    <= pick;
        tx_type  <= bus.iface_type[pick*8 +: 8];
        tx_bytes <= bus.iface_bytes[pick*BW +: BW];
        tx_size  <= clamp(bus.iface_size[pick*SIZE_WIDTH +: SIZE_WIDTH]);
      end
      if (state == ST_LOAD) ptr <= grant;
    end
  end

`ifdef MIN_OS_TX_TIMEOUT_EN
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)                                   wait_cnt <= '0;
    else if (state == ST_WAIT && state_nx == ST_WAIT) wait_cnt <= wait_cnt + 32'd1;
    else                                            wait_cnt <= '0;
  end
  assign bus.tx_timeout = timeout;
`endif

  assign bus.iface_ack          = ack;
  assign bus.tx_is_chunk_ready  = strobe;
  assign bus.tx_chunk_type      = tx_type;
  assign bus.tx_chunk_bytes     = tx_bytes;
  assign bus.tx_chunk_byte_size = tx_size;
  assign bus.busy               = (state != ST_IDLE);

  // RX routing: lowest-index type match, registered one cycle.
  logic                  rx_hit;
  logic [PTR_W-1:0]      rx_idx;
  logic [NUM_IFACES-1:0] rx_valid;
  logic [BW-1:0]         rx_bytes;
  logic [SIZE_WIDTH-1:0] rx_size;
  logic                  rx_unk;

  always_comb begin
    rx_hit = 1'b0;
    rx_idx = '0;
    for (int unsigned i = 0; i < NUM_IFACES; i++) begin
      if (!rx_hit && IFACE_TYPES[i*8 +: 8] == bus.rx_chunk_type) begin
        rx_hit = 1'b1;
        rx_idx = PTR_W'(i);
      end
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      rx_valid <= '0;
      rx_bytes <= '0;
      rx_size  <= '0;
      rx_unk   <= 1'b0;
    end else begin
      rx_valid <= '0;
      rx_unk   <= 1'b0;
      if (bus.rx_is_chunk_ready) begin
        if (rx_hit) begin
          rx_valid[rx_idx] <= 1'b1;
          rx_bytes         <= bus.rx_chunk_bytes;
          rx_size          <= clamp(bus.rx_chunk_byte_size);
        end else begin
          rx_unk <= 1'b1;
        end
      end
    end
  end

  assign bus.iface_rx_valid = rx_valid;
  assign bus.iface_rx_bytes = rx_bytes;
  assign bus.iface_rx_size  = rx_size;
  assign bus.rx_unknown     = rx_unk;
endmodule

// File: tb/tb_min_os_scheduler.sv
// Randomized self-checking bench for min_os_scheduler against a round-robin / type-routing reference model.
module tb_min_os_scheduler;
  localparam int N  = 4;
  localparam int MB = 5;
  localparam int SW = 32;
  localparam logic [31:0] TYPES = 32'h04030201;

  logic CLK;
  logic reset_n;
  int   checks;
  int   errors;
  int   m_ptr;
  logic [39:0] m_rx_bytes;
  logic [31:0] m_rx_size;

  min_os_scheduler_if #(.NUM_IFACES(N), .MAX_CHUNK_BYTES(MB), .SIZE_WIDTH(SW)) bus ();

  min_os_scheduler #(
    .NUM_IFACES(N), .MAX_CHUNK_BYTES(MB), .SIZE_WIDTH(SW), .IFACE_TYPES(TYPES)
`ifdef MIN_OS_TX_TIMEOUT_EN
    , .TIMEOUT_CYCLES(50)
`endif
  ) dut (.CLK(CLK), .reset_n(reset_n), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int model_pick(input logic [3:0] req, input int ptr);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [31:0] model_clamp(input logic [31:0] s);
    return (s > 32'(MB)) ? 32'(MB) : s;
  endfunction

  function automatic logic [39:0] rand40();
    return {8'($urandom), 32'($urandom)};
  endfunction

  task automatic set_iface(input int i, input logic [7:0] t, input logic [39:0] b, input logic [31:0] s);
    bus.iface_type[i*8 +: 8]   = t;
    bus.iface_bytes[i*40 +: 40] = b;
    bus.iface_size[i*32 +: 32] = s;
  endtask

  task automatic observe_ack(output bit got, output logic [3:0] ack, output logic stb,
                             output logic [7:0] ty, output logic [39:0] by, output logic [31:0] sz);
    got = 0; ack = '0; stb = 0; ty = '0; by = '0; sz = '0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (|bus.iface_ack) begin
        got = 1; ack = bus.iface_ack; stb = bus.tx_is_chunk_ready;
        ty = bus.tx_chunk_type; by = bus.tx_chunk_bytes; sz = bus.tx_chunk_byte_size;
      end
    end
  endtask

  // Returns with done just dropped (FSM in FINISH); counts stray acks/strobes on the way.
  task automatic finish_tx(input int dly, output int extra);
    extra = 0;
    for (int c = 0; c < dly; c++) begin
      tick();
      if (|bus.iface_ack || bus.tx_is_chunk_ready) extra++;
    end
    bus.tx_is_chunker_done = 1'b1;
    tick();
    bus.tx_is_chunker_done = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    for (int c = 0; c < 20 && bus.busy; c++) tick();
    ok = !bus.busy;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    bus.iface_req = '0; bus.iface_type = '0; bus.iface_bytes = '0; bus.iface_size = '0;
    bus.tx_is_chunker_done = 1'b0; bus.rx_is_chunk_ready = 1'b0;
    bus.rx_chunk_type = '0; bus.rx_chunk_bytes = '0; bus.rx_chunk_byte_size = '0;
    repeat (3) @(posedge CLK);
    #1;
    reset_n = 1'b1;
    m_ptr = N - 1; m_rx_bytes = '0; m_rx_size = '0;
    tick();
  endtask

  function automatic logic [127:0] all_outs();
    return {bus.iface_ack, bus.tx_is_chunk_ready, bus.tx_chunk_type, bus.tx_chunk_bytes,
            bus.tx_chunk_byte_size, bus.iface_rx_valid, bus.iface_rx_bytes, bus.iface_rx_size,
            bus.rx_unknown, bus.busy};
  endfunction

  task automatic test_reset();
    apply_reset();
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h expected=0", all_outs());
    end
  endtask

  task automatic test_single();
    bit got; logic [3:0] ack; logic stb; logic [7:0] ty; logic [39:0] by; logic [31:0] sz; int extra;
    set_iface(2, 8'h03, 40'hA5, 32'd1);
    bus.iface_req = 4'b0100;
    observe_ack(got, ack, stb, ty, by, sz);
    bus.iface_req = '0;
    checks++;
    if (!got || ack !== 4'b0100 || stb !== 1'b1) begin
      errors++; $display("FAIL single_ack got=%0d ack=%b stb=%b expected ack=0100 stb=1", got, ack, stb);
    end
    checks++;
    if (ty !== 8'h03 || by[7:0] !== 8'hA5 || sz !== 32'd1) begin
      errors++; $display("FAIL single_data type=%h byte0=%h size=%0d expected 03 A5 1", ty, by[7:0], sz);
    end
    m_ptr = 2;
    finish_tx(20, extra);
    checks++;
    if (extra != 0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL single_finish extra=%0d busy=%b expected 0 1", extra, bus.busy);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL single_busy_fall busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_round_robin();
    bit got; logic [3:0] ack; logic stb; logic [7:0] ty; logic [39:0] by; logic [31:0] sz;
    int extra, exp; bit ok;
    logic [7:0] t[4]; logic [39:0] b[4]; logic [31:0] s[4];
    apply_reset();
    for (int i = 0; i < N; i++) begin
      t[i] = 8'($urandom); b[i] = rand40(); s[i] = 32'($urandom_range(1, MB));
      set_iface(i, t[i], b[i], s[i]);
    end
    bus.iface_req = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      exp = model_pick(4'b1111, m_ptr);
      observe_ack(got, ack, stb, ty, by, sz);
      if (g == 5) bus.iface_req = '0;
      checks++;
      if (!got || ack !== 4'(1 << exp) || ty !== t[exp] || by !== b[exp] || sz !== s[exp]) begin
        errors++;
        $display("FAIL rr_grant%0d ack=%b type=%h size=%0d expected ack=%b type=%h size=%0d",
                 g, ack, ty, sz, 4'(1 << exp), t[exp], s[exp]);
      end
      m_ptr = exp;
      finish_tx(5, extra);
      checks++;
      if (extra != 0) begin
        errors++; $display("FAIL rr_single_ack%0d extra=%0d expected 0", g, extra);
      end
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_idle busy=1 expected 0"); end
  endtask

  task automatic test_size_rules();
    bit got; logic [3:0] ack; logic stb; logic [7:0] ty; logic [39:0] by; logic [31:0] sz;
    int extra; bit ok;
    set_iface(1, 8'h22, rand40(), 32'd9);
    bus.iface_req = 4'b0010;
    observe_ack(got, ack, stb, ty, by, sz);
    bus.iface_req = '0;
    checks++;
    if (!got || ack !== 4'b0010 || stb !== 1'b1 || sz !== 32'd5) begin
      errors++; $display("FAIL clamp ack=%b stb=%b size=%0d expected 0010 1 5", ack, stb, sz);
    end
    m_ptr = 1;
    finish_tx(3, extra);
    wait_idle(ok);
    set_iface(3, 8'h44, rand40(), 32'd0);
    bus.iface_req = 4'b1000;
    observe_ack(got, ack, stb, ty, by, sz);
    bus.iface_req = '0;
    checks++;
    if (!got || ack !== 4'b1000 || stb !== 1'b0) begin
      errors++; $display("FAIL zero_size ack=%b stb=%b expected 1000 0", ack, stb);
    end
    m_ptr = 3;
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.tx_is_chunk_ready !== 1'b0) begin
      errors++; $display("FAIL zero_finish busy=%b stb=%b expected 1 0", bus.busy, bus.tx_is_chunk_ready);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL zero_idle busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_random_tx();
    bit got; logic [3:0] ack; logic stb; logic [7:0] ty; logic [39:0] by; logic [31:0] sz;
    int extra, exp; bit ok; logic [3:0] mask;
    logic [7:0] t[4]; logic [39:0] b[4]; logic [31:0] s[4];
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < N; i++) begin
        t[i] = 8'($urandom); b[i] = rand40(); s[i] = 32'($urandom_range(0, 9));
        set_iface(i, t[i], b[i], s[i]);
      end
      mask = 4'($urandom_range(1, 15));
      exp = model_pick(mask, m_ptr);
      bus.iface_req = mask;
      observe_ack(got, ack, stb, ty, by, sz);
      bus.iface_req = '0;
      checks++;
      if (!got || ack !== 4'(1 << exp) || stb !== (s[exp] != 0) || ty !== t[exp] ||
          by !== b[exp] || sz !== model_clamp(s[exp])) begin
        errors++;
        $display("FAIL rand_tx%0d mask=%b ack=%b stb=%b type=%h size=%0d expected ack=%b stb=%b type=%h size=%0d",
                 it, mask, ack, stb, ty, sz, 4'(1 << exp), (s[exp] != 0), t[exp], model_clamp(s[exp]));
      end
      m_ptr = exp;
      extra = 0;
      if (s[exp] != 0) finish_tx($urandom_range(2, 8), extra);
      wait_idle(ok);
      checks++;
      if (extra != 0 || !ok) begin
        errors++; $display("FAIL rand_tx_end%0d extra=%0d idle=%0d expected 0 1", it, extra, ok);
      end
    end
  endtask

  task automatic test_rx();
    logic rdy; logic [7:0] ty; logic [39:0] by; logic [31:0] sz;
    logic [3:0] exp_valid; logic exp_unk; int idx;
    for (int it = 0; it < 24; it++) begin
      case (it)
        0: begin rdy = 1; ty = 8'h02; by = 40'h5A; sz = 32'd1; end
        1: begin rdy = 1; ty = 8'h7F; by = rand40(); sz = 32'd3; end
        default: begin
          rdy = ($urandom_range(0, 3) != 0);
          ty  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(1, 4));
          by  = rand40();
          sz  = 32'($urandom_range(0, 9));
        end
      endcase
      bus.rx_is_chunk_ready = rdy; bus.rx_chunk_type = ty;
      bus.rx_chunk_bytes = by; bus.rx_chunk_byte_size = sz;
      exp_valid = '0; exp_unk = 0; idx = -1;
      if (rdy) begin
        for (int j = 0; j < N; j++)
          if (idx < 0 && TYPES[j*8 +: 8] == ty) idx = j;
        if (idx >= 0) begin
          exp_valid[idx] = 1'b1; m_rx_bytes = by; m_rx_size = model_clamp(sz);
        end else begin
          exp_unk = 1'b1;
        end
      end
      tick();
      checks++;
      if (bus.iface_rx_valid !== exp_valid || bus.rx_unknown !== exp_unk ||
          bus.iface_rx_bytes !== m_rx_bytes || bus.iface_rx_size !== m_rx_size) begin
        errors++;
        $display("FAIL rx%0d type=%h valid=%b unk=%b bytes=%h size=%0d expected %b %b %h %0d",
                 it, ty, bus.iface_rx_valid, bus.rx_unknown, bus.iface_rx_bytes, bus.iface_rx_size,
                 exp_valid, exp_unk, m_rx_bytes, m_rx_size);
      end
    end
    bus.rx_is_chunk_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit got; logic [3:0] ack; logic stb; logic [7:0] ty; logic [39:0] by; logic [31:0] sz;
    int extra; bit ok;
    set_iface(1, 8'h11, rand40(), 32'd3);
    bus.iface_req = 4'b0010;
    observe_ack(got, ack, stb, ty, by, sz);
    bus.iface_req = '0;
    tick(); tick();
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_wait busy=%b expected 1", bus.busy); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL mid_reset_outputs got=%h expected=0", all_outs());
    end
    tick();
    reset_n = 1'b1;
    m_ptr = N - 1; m_rx_bytes = '0; m_rx_size = '0;
    set_iface(0, 8'h10, rand40(), 32'd2);
    set_iface(3, 8'h30, rand40(), 32'd2);
    bus.iface_req = 4'b1001;
    observe_ack(got, ack, stb, ty, by, sz);
    bus.iface_req = '0;
    checks++;
    if (!got || ack !== 4'(1 << model_pick(4'b1001, m_ptr)) || ty !== 8'h10) begin
      errors++; $display("FAIL mid_first_grant ack=%b type=%h expected 0001 10", ack, ty);
    end
    m_ptr = 0;
    finish_tx(3, extra);
    wait_idle(ok);
  endtask

`ifdef MIN_OS_TX_TIMEOUT_EN
  task automatic test_timeout();
    bit got; logic [3:0] ack; logic stb; logic [7:0] ty; logic [39:0] by; logic [31:0] sz;
    int n, extra; bit ok; bit seen;
    set_iface(2, 8'h03, rand40(), 32'd2);
    bus.iface_req = 4'b0100;
    observe_ack(got, ack, stb, ty, by, sz);
    bus.iface_req = '0;
    n = 0; seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      tick(); n++;
      if (bus.tx_timeout) seen = 1;
    end
    checks++;
    if (!seen || n != 51) begin
      errors++; $display("FAIL timeout_pulse seen=%0d cycles=%0d expected 1 51", seen, n);
    end
    m_ptr = 2;
    tick();
    checks++;
    if (bus.tx_timeout !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL timeout_finish pulse=%b busy=%b expected 0 1", bus.tx_timeout, bus.busy);
    end
    tick();
    set_iface(0, 8'h77, rand40(), 32'd1);
    bus.iface_req = 4'b0001;
    observe_ack(got, ack, stb, ty, by, sz);
    bus.iface_req = '0;
    checks++;
    if (!got || ack !== 4'b0001 || ty !== 8'h77) begin
      errors++; $display("FAIL timeout_next ack=%b type=%h expected 0001 77", ack, ty);
    end
    m_ptr = 0;
    finish_tx(3, extra);
    wait_idle(ok);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_size_rules();
    test_random_tx();
    test_rx();
    test_reset_mid();
`ifdef MIN_OS_TX_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
